// File: rtl/dffrf_pkg.sv
// Shared definitions for the DFFRF_2R1W register-file controller.
package dffrf_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dffrf_2r1w_ctrl.sv
// Initiator-side controller for the DFFRF_2R1W macro: zero-fill after reset,
// then valid/ready reads and writes with same-cycle write->read bypass.
module dffrf_2r1w_ctrl
    import dffrf_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic          CLK,
    input  logic          RST_N,
    output logic          INIT_DONE,
    input  logic          RD_VALID,
    output logic          RD_READY,
    input  logic [AW-1:0] RD_A,
    input  logic [AW-1:0] RD_B,
    output logic          RSP_VALID,
    output logic [DW-1:0] RSP_DA,
    output logic [DW-1:0] RSP_DB,
    input  logic          WR_VALID,
    output logic          WR_READY,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [DW-1:0] WR_DATA,
    output logic          RF_WE,
    output logic [AW-1:0] RF_RW,
    output logic [DW-1:0] RF_DW,
    output logic [AW-1:0] RF_RA,
    output logic [AW-1:0] RF_RB,
    input  logic [DW-1:0] RF_DA,
    input  logic [DW-1:0] RF_DB
);

    // state   | meaning
    // ST_INIT | zero-filling entries 0..2**AW-1, requests refused
    // ST_RUN  | serving read pairs and writes every cycle

    state_t          state;
    logic [AW-1:0]   fill_cnt;
    logic            run;
    logic            rd_acc;
    logic            wr_acc;
    logic            wr_do;
    logic            rsp_v;
    logic [AW-1:0]   rd_a_q;
    logic [AW-1:0]   rd_b_q;
    logic            byp_v;
    logic [AW-1:0]   byp_addr;
    logic [DW-1:0]   byp_data;
    logic [DW-1:0]   hold_da;
    logic [DW-1:0]   hold_db;
    logic [DW-1:0]   mux_da;
    logic [DW-1:0]   mux_db;

    assign run      = (state == ST_RUN);
    assign RD_READY = run;
    assign WR_READY = run;
    assign rd_acc   = RD_VALID & run;
    assign wr_acc   = WR_VALID & run;
    assign wr_do    = wr_acc & ~(ZERO_R0 && (WR_ADDR == '0));

    assign RF_RA = RD_A;
    assign RF_RB = RD_B;

    always_comb begin
        RF_WE = 1'b1;
        RF_RW = fill_cnt;
        RF_DW = '0;
        if (run) begin
            RF_WE = wr_do;
            RF_RW = WR_ADDR;
            RF_DW = WR_DATA;
        end
    end

    // The macro returns pre-write data on a collision, so a write from the
    // acceptance cycle overrides it; hardwired zero has the last word.
    always_comb begin
        mux_da = RF_DA;
        mux_db = RF_DB;
        if (byp_v && (byp_addr == rd_a_q)) mux_da = byp_data;
        if (byp_v && (byp_addr == rd_b_q)) mux_db = byp_data;
        if (ZERO_R0 && (rd_a_q == '0)) mux_da = '0;
        if (ZERO_R0 && (rd_b_q == '0)) mux_db = '0;
    end

    // Macro data arrives in the response cycle itself; holding registers keep
    // the last delivered value stable while no response is presented.
    assign RSP_VALID = rsp_v;
    assign RSP_DA    = rsp_v ? mux_da : hold_da;
    assign RSP_DB    = rsp_v ? mux_db : hold_db;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_INIT;
            fill_cnt  <= '0;
            INIT_DONE <= 1'b0;
            rsp_v     <= 1'b0;
            rd_a_q    <= '0;
            rd_b_q    <= '0;
            byp_v     <= 1'b0;
            byp_addr  <= '0;
            byp_data  <= '0;
            hold_da   <= '0;
            hold_db   <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt == '1) begin
                        state     <= ST_RUN;
                        INIT_DONE <= 1'b1;
                    end
                end
                ST_RUN: ;
                default: state <= ST_INIT;
            endcase

            rsp_v <= rd_acc;
            byp_v <= wr_do;
            if (rd_acc) begin
                rd_a_q <= RD_A;
                rd_b_q <= RD_B;
            end
            if (wr_do) begin
                byp_addr <= WR_ADDR;
                byp_data <= WR_DATA;
            end
            if (rsp_v) begin
                hold_da <= mux_da;
                hold_db <= mux_db;
            end
        end
    end

endmodule

// File: tb/tb_dffrf_2r1w_ctrl.sv
// Bench: two controllers (ZERO_R0=0 and 1) each with a DFFRF_2R1W model,
// driven by shared stimulus and checked against an array-based reference.
module tb_dffrf_2r1w_ctrl;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int N  = 32;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          RD_VALID;
    logic [AW-1:0] RD_A;
    logic [AW-1:0] RD_B;
    logic          WR_VALID;
    logic [AW-1:0] WR_ADDR;
    logic [DW-1:0] WR_DATA;

    // index 0: ZERO_R0=0, index 1: ZERO_R0=1
    logic [1:0]    init_done;
    logic [1:0]    rd_ready;
    logic [1:0]    wr_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_da [2];
    logic [DW-1:0] rsp_db [2];
    logic [1:0]    rf_we;
    logic [AW-1:0] rf_rw [2];
    logic [DW-1:0] rf_dw [2];
    logic [AW-1:0] rf_ra [2];
    logic [AW-1:0] rf_rb [2];
    logic [DW-1:0] rf_da [2];
    logic [DW-1:0] rf_db [2];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [DW-1:0] mem [N];

        dffrf_2r1w_ctrl #(.AW(AW), .DW(DW), .ZERO_R0(g == 1)) u_dut (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .INIT_DONE (init_done[g]),
            .RD_VALID  (RD_VALID),
            .RD_READY  (rd_ready[g]),
            .RD_A      (RD_A),
            .RD_B      (RD_B),
            .RSP_VALID (rsp_valid[g]),
            .RSP_DA    (rsp_da[g]),
            .RSP_DB    (rsp_db[g]),
            .WR_VALID  (WR_VALID),
            .WR_READY  (wr_ready[g]),
            .WR_ADDR   (WR_ADDR),
            .WR_DATA   (WR_DATA),
            .RF_WE     (rf_we[g]),
            .RF_RW     (rf_rw[g]),
            .RF_DW     (rf_dw[g]),
            .RF_RA     (rf_ra[g]),
            .RF_RB     (rf_rb[g]),
            .RF_DA     (rf_da[g]),
            .RF_DB     (rf_db[g])
        );

        // Macro model: synchronous reads return pre-write data on collision.
        always @(posedge CLK) begin
            if (rf_we[g]) mem[rf_rw[g]] <= rf_dw[g];
            rf_da[g] <= mem[rf_ra[g]];
            rf_db[g] <= mem[rf_rb[g]];
        end

        initial begin
            for (int i = 0; i < N; i++) mem[i] = $urandom;
        end
    end

    logic [DW-1:0] ref_mem [2][N];
    logic [DW-1:0] hold_a [2];
    logic [DW-1:0] hold_b [2];
    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < N; i++) ref_mem[g][i] = '0;
            hold_a[g] = '0;
            hold_b[g] = '0;
        end
    endtask

    // Reset, release, and verify the full zero-fill sequence.
    task automatic init_seq();
        RD_VALID = 1'b0;
        WR_VALID = 1'b0;
        RST_N    = 1'b0;
        repeat (2) @(negedge CLK);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rst_rsp_valid%0d", g), rsp_valid[g], '0);
            chk($sformatf("rst_rsp_da%0d", g), rsp_da[g], '0);
            chk($sformatf("rst_rsp_db%0d", g), rsp_db[g], '0);
            chk($sformatf("rst_init_done%0d", g), init_done[g], '0);
        end
        RST_N = 1'b1;
        model_reset();
        for (int i = 0; i < N; i++) begin
            #1;
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("fill_we%0d_%0d", g, i), rf_we[g], 1);
                chk($sformatf("fill_rw%0d_%0d", g, i), rf_rw[g], i);
                chk($sformatf("fill_dw%0d_%0d", g, i), rf_dw[g], '0);
                chk($sformatf("fill_done%0d_%0d", g, i), init_done[g], '0);
                chk($sformatf("fill_rdy%0d_%0d", g, i), {rd_ready[g], wr_ready[g]}, '0);
            end
            @(negedge CLK);
        end
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("init_done%0d", g), init_done[g], 1);
            chk($sformatf("post_fill_we%0d", g), rf_we[g], '0);
            chk($sformatf("run_rdy%0d", g), {rd_ready[g], wr_ready[g]}, 2'b11);
        end
        @(negedge CLK);
    endtask

    // One RUN cycle: drive at negedge, check the response at the next negedge.
    task automatic cyc(input logic rv, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        logic [DW-1:0] ea [2];
        logic [DW-1:0] eb [2];
        RD_VALID = rv;
        RD_A     = ra;
        RD_B     = rb;
        WR_VALID = wv;
        WR_ADDR  = wa;
        WR_DATA  = wd;
        for (int g = 0; g < 2; g++) begin
            if (wv && !(g == 1 && wa == 0)) ref_mem[g][wa] = wd;
            ea[g] = (g == 1 && ra == 0) ? '0 : ref_mem[g][ra];
            eb[g] = (g == 1 && rb == 0) ? '0 : ref_mem[g][rb];
        end
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rf_we%0d", g), rf_we[g], (wv && !(g == 1 && wa == 0)) ? 1 : 0);
            if (wv) chk($sformatf("rf_rw%0d", g), rf_rw[g], wa);
        end
        @(negedge CLK);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("rsp_valid%0d", g), rsp_valid[g], rv);
            if (rv) begin
                hold_a[g] = ea[g];
                hold_b[g] = eb[g];
            end
            chk($sformatf("rsp_da%0d", g), rsp_da[g], hold_a[g]);
            chk($sformatf("rsp_db%0d", g), rsp_db[g], hold_b[g]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N    = 1'b0;
        RD_VALID = 1'b0;
        RD_A     = '0;
        RD_B     = '0;
        WR_VALID = 1'b0;
        WR_ADDR  = '0;
        WR_DATA  = '0;
        model_reset();
        @(negedge CLK);

        init_seq();
        for (int i = 0; i < N; i++) cyc(1'b1, AW'(i), AW'(N - 1 - i), 1'b0, '0, '0);

        cyc(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
        cyc(1'b1, 5'd5, 5'd6, 1'b0, '0, '0);
        chk("wr5_da", rsp_da[1], 32'hDEADBEEF);
        chk("wr5_db", rsp_db[1], '0);

        cyc(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678);
        chk("byp_da", rsp_da[1], 32'h12345678);
        chk("byp_db", rsp_db[1], 32'h12345678);
        cyc(1'b0, '0, '0, 1'b0, '0, '0);

        cyc(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
        cyc(1'b1, 5'd0, 5'd0, 1'b0, '0, '0);
        chk("r0_z1", rsp_da[1], '0);
        chk("r0_z0", rsp_da[0], 32'hFFFFFFFF);

        cyc(1'b0, '0, '0, 1'b1, 5'd3, 32'hA5A5A5A5);
        RD_VALID = 1'b1;
        RD_A     = 5'd3;
        RD_B     = 5'd3;
        WR_VALID = 1'b0;
        RST_N    = 1'b0;
        @(negedge CLK);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("midrst_valid%0d", g), rsp_valid[g], '0);
            chk($sformatf("midrst_da%0d", g), rsp_da[g], '0);
        end
        init_seq();
        cyc(1'b1, 5'd3, 5'd3, 1'b0, '0, '0);
        chk("post_rst_e3", rsp_da[1], '0);

        repeat (100) cyc(1'b1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        repeat (60) cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, N - 1)),
                        5'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, N - 1)), $urandom);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
